// File: rtl/nibble_serial_adder_if.sv
// rtl/nibble_serial_adder_if.sv - request/result bundle for the nibble-serial adder
interface nibble_serial_adder_if #(
    parameter int NIB = 4
) ();
    localparam int W = 4 * NIB;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - W-bit adder processing one 4-bit lookahead nibble per cycle
module nibble_serial_adder #(
    parameter int NIB = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    nibble_serial_adder_if.slave  bus
);
    localparam int W  = 4 * NIB;
    localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic           carry_q;
    logic [W-1:0]   sum_q;
    logic           cout_q;
    logic           ovf_q;
    logic           busy_q;
    logic           done_q;

    logic [3:0]     nib_a;
    logic [3:0]     nib_b;
    logic [3:0]     nib_p;
    logic [3:0]     nib_g;
    logic [4:0]     nib_c;
    logic [3:0]     nib_s;
    logic           last_nib;

    always_comb begin
        nib_a    = a_q[{cnt_q, 2'b00} +: 4];
        nib_b    = b_q[{cnt_q, 2'b00} +: 4];
        nib_p    = nib_a ^ nib_b;
        nib_g    = nib_a & nib_b;
        nib_c    = 5'b0;
        nib_c[0] = carry_q;
        for (int i = 0; i < 4; i++) begin
            nib_c[i+1] = nib_g[i] | (nib_p[i] & nib_c[i]);
        end
        nib_s    = nib_p ^ nib_c[3:0];
        last_nib = (cnt_q == CW'(NIB - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    // DONE accepts a new request exactly like IDLE, so back-to-back adds need no bubble
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        carry_q <= bus.cin;
                        cnt_q   <= '0;
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                S_RUN: begin
                    sum_q[{cnt_q, 2'b00} +: 4] <= nib_s;
                    carry_q                    <= nib_c[4];
                    if (last_nib) begin
                        cout_q  <= nib_c[4];
                        ovf_q   <= nib_c[3] ^ nib_c[4];
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - directed and random checks against an arithmetic reference
module tb_nibble_serial_adder;
    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    nibble_serial_adder_if #(.NIB(NIB)) bus ();

    nibble_serial_adder #(.NIB(NIB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                           output logic [W-1:0] s, output logic co, output logic ov);
        logic [W:0] t;
        t  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        s  = t[W-1:0];
        co = t[W];
        ov = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    endtask

    task automatic wait_done(output bit seen, output int nbusy);
        int n;
        n     = 0;
        nbusy = 0;
        while (!bus.done && n < 20) begin
            if (bus.busy) nbusy++;
            @(negedge clk);
            n++;
        end
        seen = bus.done;
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic cin, input bit seen, input int nbusy);
        logic [W-1:0] es;
        logic         eco;
        logic         eov;
        ref_add(a, b, cin, es, eco, eov);
        check({tag, ".done_seen"}, 32'(seen), 32'd1);
        check({tag, ".busy_cycles"}, 32'(nbusy), 32'(NIB));
        check({tag, ".sum"}, 32'(bus.sum), 32'(es));
        check({tag, ".cout"}, 32'(bus.cout), 32'(eco));
        check({tag, ".ovf"}, 32'(bus.ovf), 32'(eov));
        check({tag, ".busy_in_done"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic do_add(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin);
        bit seen;
        int nbusy;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(seen, nbusy);
        check_result(tag, a, b, cin, seen, nbusy);
        @(negedge clk);
        check({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        bit seen;
        int nbusy;
        int done_hits;
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.a       = '0;
        bus.b       = '0;
        bus.cin     = 1'b0;

        @(negedge clk);
        check("reset.busy", 32'(bus.busy), 32'd0);
        check("reset.done", 32'(bus.done), 32'd0);
        check("reset.sum", 32'(bus.sum), 32'd0);
        check("reset.cout", 32'(bus.cout), 32'd0);
        check("reset.ovf", 32'(bus.ovf), 32'd0);

        bus.start = 1'b1;
        bus.a     = 16'h1111;
        bus.b     = 16'h1111;
        @(negedge clk);
        check("start_in_reset.busy", 32'(bus.busy), 32'd0);
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("after_release.busy", 32'(bus.busy), 32'd0);

        do_add("carry_wrap", 16'hFFFF, 16'h0001, 1'b0);
        do_add("pos_ovf", 16'h7FFF, 16'h0001, 1'b0);
        do_add("cin_add", 16'h1234, 16'h4321, 1'b1);

        // start pulsed during RUN must be ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h8000;
        bus.b     = 16'h8000;
        bus.cin   = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h0001;
        bus.b     = 16'h0001;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(seen, nbusy);
        check_result("ignore_start", 16'h8000, 16'h8000, 1'b0, seen, nbusy + 2);
        done_hits = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) done_hits++;
        end
        check("ignore_start.no_second", 32'(done_hits), 32'd0);

        // back-to-back start accepted in the DONE cycle
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h00FF;
        bus.b     = 16'h0001;
        bus.cin   = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(seen, nbusy);
        check_result("b2b_first", 16'h00FF, 16'h0001, 1'b0, seen, nbusy);
        bus.start = 1'b1;
        bus.a     = 16'h0F0F;
        bus.b     = 16'h0101;
        @(negedge clk);
        check("b2b.no_bubble", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        wait_done(seen, nbusy);
        check_result("b2b_second", 16'h0F0F, 16'h0101, 1'b0, seen, nbusy);

        // reset during the third RUN cycle aborts the addition
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h1111;
        bus.b     = 16'h2222;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort.busy", 32'(bus.busy), 32'd0);
        check("abort.done", 32'(bus.done), 32'd0);
        check("abort.sum", 32'(bus.sum), 32'd0);
        check("abort.cout", 32'(bus.cout), 32'd0);
        check("abort.ovf", 32'(bus.ovf), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        done_hits = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done) done_hits++;
        end
        check("abort.no_done", 32'(done_hits), 32'd0);
        do_add("after_abort", 16'h0002, 16'h0003, 1'b0);

        for (int i = 0; i < 16; i++) begin
            do_add($sformatf("rand%0d", i), W'($urandom), W'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
